// File: rtl/ysyx_23060187_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_pkg
//  Description : Shared constants for the PC generator: branch funct3 codes,
//                PC-generator FSM state encoding and default reset vector.
//  Revision    : 1.0  initial release
// ============================================================================
package ysyx_23060187_pkg;

  // Conditional-branch funct3 encodings (010 and 011 are unused by RV32I)
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  // PC-generator FSM state encoding
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;

  // Architectural reset vector
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h8000_0000;

endpackage
`default_nettype wire

// File: rtl/ysyx_23060187_br_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_br_cmp
//  Description : Combinational branch comparator. Resolves the taken
//                decision for the six RV32I conditional branches and flags
//                reserved funct3 codes.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_23060187_br_cmp
  import ysyx_23060187_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      br_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            taken,
  output logic            illegal
);

  // Decode funct3 into a compare; reserved codes are never taken
  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (br_op)
      BR_EQ:   taken = (src1 == src2);
      BR_NE:   taken = (src1 != src2);
      BR_LT:   taken = ($signed(src1) <  $signed(src2));
      BR_GE:   taken = ($signed(src1) >= $signed(src2));
      BR_LTU:  taken = (src1 <  src2);
      BR_GEU:  taken = (src1 >= src2);
      default: illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_23060187_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_23060187_pc_gen
//  Description : Architectural PC holder for the multi-cycle core. Offers the
//                PC to the IFU with valid/ready, waits for the EXU commit,
//                then computes the next PC (seq/JAL/JALR/branch/trap/MRET)
//                and maintains retire and redirect counters.
//  Revision    : 1.0  initial release
// ============================================================================
module ysyx_23060187_pc_gen
  import ysyx_23060187_pkg::*;
#(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
  parameter int                CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [XLEN-1:0]   pc,
  output logic              pc_valid,
  input  logic              pc_ready,
  input  logic              commit_valid,
  input  logic              is_jal,
  input  logic              is_jalr,
  input  logic              is_branch,
  input  logic              is_trap,
  input  logic              is_mret,
  input  logic [2:0]        br_op,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   mtvec,
  input  logic [XLEN-1:0]   mepc,
  output logic              misalign,
  output logic              proto_err,
  output logic [CNT_W-1:0]  instret,
  output logic [CNT_W-1:0]  redirect_cnt
);

  logic [1:0]       r_state;
  logic [XLEN-1:0]  r_pc;
  logic             r_misalign;
  logic             r_proto_err;
  logic [CNT_W-1:0] r_instret;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic             w_br_taken;
  logic             w_br_illegal;
  logic [XLEN-1:0]  w_next_pc;
  logic [XLEN-1:0]  w_target;
  logic             w_target_chk;
  logic             w_redirect;
  logic             w_misalign;
  logic             w_br_used;
  logic             w_commit;

  ysyx_23060187_br_cmp #(
    .XLEN (XLEN)
  ) u_br_cmp (
    .br_op   (br_op),
    .src1    (src1),
    .src2    (src2),
    .taken   (w_br_taken),
    .illegal (w_br_illegal)
  );

  assign w_commit = (r_state == S_EXEC) && commit_valid;

  // Prioritised next-PC selection; computed targets with bit 1 set trap to mtvec
  always_comb begin
    w_target     = r_pc + XLEN'(4);
    w_target_chk = 1'b0;
    w_redirect   = 1'b0;
    w_br_used    = 1'b0;
    if (is_trap) begin
      w_target   = mtvec;
      w_redirect = 1'b1;
    end else if (is_mret) begin
      w_target   = mepc;
      w_redirect = 1'b1;
    end else if (is_jal) begin
      w_target     = r_pc + imm;
      w_target_chk = 1'b1;
      w_redirect   = 1'b1;
    end else if (is_jalr) begin
      w_target     = (src1 + imm) & ~XLEN'(1);
      w_target_chk = 1'b1;
      w_redirect   = 1'b1;
    end else if (is_branch) begin
      w_br_used = 1'b1;
      if (w_br_taken) begin
        w_target     = r_pc + imm;
        w_target_chk = 1'b1;
        w_redirect   = 1'b1;
      end
    end
    w_misalign = w_target_chk && w_target[1];
    w_next_pc  = w_misalign ? mtvec : w_target;
  end

  // FSM, PC register, error flag and performance counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_VEC;
      r_misalign     <= 1'b0;
      r_proto_err    <= 1'b0;
      r_instret      <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_misalign <= 1'b0;
      case (r_state)
        S_BOOT:  r_state <= S_FETCH;
        S_FETCH: if (pc_ready) r_state <= S_EXEC;
        S_EXEC:  if (commit_valid) r_state <= S_FETCH;
        default: r_state <= S_BOOT;
      endcase
      if (w_commit) begin
        r_pc       <= w_next_pc;
        r_misalign <= w_misalign;
        r_instret  <= r_instret + CNT_W'(1);
        if (w_redirect) r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        if (w_br_used && w_br_illegal) r_proto_err <= 1'b1;
      end
      // A commit outside EXEC is dropped but remembered as a protocol error
      if (commit_valid && (r_state != S_EXEC)) r_proto_err <= 1'b1;
    end
  end

  assign pc           = r_pc;
  assign pc_valid     = (r_state == S_FETCH);
  assign misalign     = r_misalign;
  assign proto_err    = r_proto_err;
  assign instret      = r_instret;
  assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060187_pc_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_23060187_pc_gen
//  Description : Scoreboard bench for the PC generator. Stimulus pushes the
//                expected next fetch PC; a monitor pops it at each handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ysyx_23060187_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready = 1'b1;
  logic        commit_valid = 1'b0;
  logic        is_jal = 1'b0, is_jalr = 1'b0, is_branch = 1'b0;
  logic        is_trap = 1'b0, is_mret = 1'b0;
  logic [2:0]  br_op = 3'b000;
  logic [31:0] src1 = '0, src2 = '0, imm = '0;
  logic [31:0] mtvec = 32'h8000_0200;
  logic [31:0] mepc  = 32'h8000_0040;
  logic        misalign, proto_err;
  logic [31:0] instret, redirect_cnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_q[$];
  int          e_instret = 0;
  int          e_redir = 0;

  ysyx_23060187_pc_gen dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .pc_ready     (pc_ready),
    .commit_valid (commit_valid),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .is_branch    (is_branch),
    .is_trap      (is_trap),
    .is_mret      (is_mret),
    .br_op        (br_op),
    .src1         (src1),
    .src2         (src2),
    .imm          (imm),
    .mtvec        (mtvec),
    .mepc         (mepc),
    .misalign     (misalign),
    .proto_err    (proto_err),
    .instret      (instret),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every fetch handshake must present the next expected PC
  always @(negedge clk) begin
    if (rst_n && pc_valid && pc_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL fetch_pc: got %h expected none (queue empty)", pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (pc !== e) begin
          errors++;
          $display("FAIL fetch_pc: got %h expected %h", pc, e);
        end
      end
    end
  end

  // Wait (bounded) for the negedge where the fetch handshake is visible
  task automatic wait_fetch();
    bit found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (pc_valid && pc_ready) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got no handshake expected one within 50 cycles");
    end
  endtask

  // Fetch, then commit one instruction in EXEC and check the commit results
  task automatic commit_op(input logic jal, jalr, br, trap, mret,
                           input logic [2:0] op,
                           input logic [31:0] s1, s2, im, exp_pc,
                           input logic exp_redir, exp_mis, exp_perr,
                           input string name);
    wait_fetch();
    @(posedge clk); #1;
    check({name, "_prev_misalign_low"}, {31'b0, misalign}, 32'd0);
    is_jal = jal; is_jalr = jalr; is_branch = br; is_trap = trap; is_mret = mret;
    br_op = op; src1 = s1; src2 = s2; imm = im;
    commit_valid = 1'b1;
    exp_q.push_back(exp_pc);
    @(posedge clk); #1;
    commit_valid = 1'b0;
    is_jal = 0; is_jalr = 0; is_branch = 0; is_trap = 0; is_mret = 0;
    e_instret++;
    if (exp_redir) e_redir++;
    check({name, "_misalign"}, {31'b0, misalign}, {31'b0, exp_mis});
    check({name, "_instret"}, instret, 32'(e_instret));
    check({name, "_redirect_cnt"}, redirect_cnt, 32'(e_redir));
    check({name, "_proto_err"}, {31'b0, proto_err}, {31'b0, exp_perr});
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 32'h8000_0000);
    check("rst_pc_valid", {31'b0, pc_valid}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_redirect", redirect_cnt, 32'd0);
    check("rst_proto_err", {31'b0, proto_err}, 32'd0);
    exp_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_cycle1_valid", {31'b0, pc_valid}, 32'd0);

    commit_op(0,0,0,0,0, 3'b000, 0, 0, 0, 32'h8000_0004, 0, 0, 0, "seq1");
    commit_op(0,0,0,0,0, 3'b000, 0, 0, 0, 32'h8000_0008, 0, 0, 0, "seq2");

    // Stall: IFU not ready for 5 cycles
    pc_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h8000_0008);
      check("stall_valid", {31'b0, pc_valid}, 32'd1);
    end
    @(posedge clk); #1;
    pc_ready = 1'b1;

    commit_op(0,0,0,0,0, 3'b000, 0, 0, 0, 32'h8000_000C, 0, 0, 0, "seq3");
    commit_op(0,0,0,0,0, 3'b000, 0, 0, 0, 32'h8000_0010, 0, 0, 0, "seq4");
    commit_op(0,0,1,0,0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0,
              32'h8000_0000, 1, 0, 0, "blt");
    commit_op(1,0,0,0,0, 3'b000, 0, 0, 32'h10, 32'h8000_0010, 1, 0, 0, "jal");
    commit_op(0,0,1,0,0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0,
              32'h8000_0014, 0, 0, 0, "bltu");
    commit_op(0,1,0,0,0, 3'b000, 32'h8000_0101, 0, 32'h2,
              32'h8000_0200, 1, 1, 0, "jalr_mis");
    commit_op(0,0,0,1,0, 3'b000, 0, 0, 0, 32'h8000_0200, 1, 0, 0, "trap");
    commit_op(0,0,0,0,1, 3'b000, 0, 0, 0, 32'h8000_0040, 1, 0, 0, "mret");
    commit_op(1,0,0,1,0, 3'b000, 0, 0, 32'h100, 32'h8000_0200, 1, 0, 0, "trap_jal");

    // Commit pulse while still in FETCH is ignored but flagged
    pc_ready = 1'b0;
    commit_valid = 1'b1;
    is_jal = 1'b1; imm = 32'h40;
    @(posedge clk); #1;
    commit_valid = 1'b0; is_jal = 1'b0;
    check("fetch_commit_proto_err", {31'b0, proto_err}, 32'd1);
    check("fetch_commit_pc", pc, 32'h8000_0200);
    check("fetch_commit_instret", instret, 32'(e_instret));
    check("fetch_commit_valid", {31'b0, pc_valid}, 32'd1);
    pc_ready = 1'b1;

    // Reset asserted in EXEC with a commit pending
    wait_fetch();
    @(posedge clk); #1;
    commit_valid = 1'b1; is_jal = 1'b1; imm = 32'h40;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 32'h8000_0000);
    check("midrst_valid", {31'b0, pc_valid}, 32'd0);
    check("midrst_misalign", {31'b0, misalign}, 32'd0);
    check("midrst_proto_err", {31'b0, proto_err}, 32'd0);
    check("midrst_instret", instret, 32'd0);
    check("midrst_redirect", redirect_cnt, 32'd0);
    @(posedge clk); #1;
    commit_valid = 1'b0; is_jal = 1'b0;
    e_instret = 0; e_redir = 0;
    exp_q.delete();
    exp_q.push_back(32'h8000_0000);
    rst_n = 1'b1;

    commit_op(0,0,1,0,0, 3'b010, 32'h5, 32'h5, 32'hFFFF_FFF0,
              32'h8000_0004, 0, 0, 1, "br_illegal");
    commit_op(0,0,1,0,0, 3'b000, 32'h5, 32'h5, 32'h8,
              32'h8000_000C, 1, 0, 1, "beq");
    commit_op(0,0,1,0,0, 3'b111, 32'h1, 32'hFFFF_FFFF, 32'h8,
              32'h8000_0010, 0, 0, 1, "bgeu");
    commit_op(0,1,0,0,0, 3'b000, 32'hFFFF_FFFC, 0, 0,
              32'hFFFF_FFFC, 1, 0, 1, "jalr_hi");
    commit_op(0,0,0,0,0, 3'b000, 0, 0, 0, 32'h0000_0000, 0, 0, 1, "seq_wrap");

    wait_fetch();
    @(posedge clk); #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_23060187_pc_gen.md
# ysyx_23060187_pc_gen

Parametrised program-counter generator for the multi-cycle core. It sits between the EXU commit point and the IFU and holds the architectural PC. It offers each PC to the IFU through a valid/ready handshake, then waits for the EXU to commit that instruction. On commit it computes the next PC on-chip (sequential, JAL, JALR, all six conditional branches, trap entry, MRET) and keeps retire and taken-redirect counters.

## Interface
Parameters:
- XLEN, 32, PC / operand width.
- RESET_VEC, 32'h8000_0000, PC value loaded on reset.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- pc  out  XLEN  current PC offered to IFU.
- pc_valid  out  1  pc is valid for fetch.
- pc_ready  in  1  IFU accepts pc.
- commit_valid  in  1  EXU commits the instruction at pc (single-cycle pulse).
- is_jal, is_jalr, is_branch, is_trap, is_mret  in  1 each  instruction class (at most one high).
- br_op  in  3  funct3 of the branch.
- src1, src2, imm  in  XLEN  rs1, rs2 and the sign-extended immediate.
- mtvec, mepc  in  XLEN  CSR values.
- misalign  out  1  one-cycle pulse: the computed target had bit 1 set.
- proto_err  out  1  sticky: commit_valid seen outside EXEC, or illegal br_op.
- instret  out  CNT_W  committed-instruction count.
- redirect_cnt  out  CNT_W  count of non-sequential next-PCs.

## Operation
- FSM states and transitions:
  - BOOT → FETCH unconditionally.
  - FETCH → EXEC when pc_valid && pc_ready.
  - EXEC → FETCH on commit_valid.
- pc_valid = (state == FETCH). pc holds steady while pc_valid is high and pc_ready is low.
- Next-PC on commit, in priority order:
  1. is_trap → mtvec.
  2. is_mret → mepc.
  3. is_jal → pc+imm.
  4. is_jalr → (src1+imm) & ~1.
  5. is_branch && taken → pc+imm.
  6. Otherwise → pc+4.
- Branch-taken rule by br_op:
  - 000 EQ, 001 NE.
  - 100 signed LT, 101 signed GE.
  - 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 are not taken and set proto_err.
- All additions are modulo 2^XLEN; wrap-around is legal (0xFFFF_FFFC+4 = 0).
- Misaligned target (bit 1 set after the jalr mask):
  - next PC = mtvec.
  - misalign pulses on the commit edge.
  - redirect_cnt increments.
- instret increments on every accepted commit.
- redirect_cnt increments whenever next-PC ≠ pc+4 by rule (trap, mret, jal, jalr, taken branch). A target that numerically equals pc+4 still counts.
- Both counters wrap at 2^CNT_W.
- commit_valid in BOOT or FETCH:
  - ignored: no PC or counter change.
  - proto_err set.
- Multiple class bits high at once: the priority above resolves it. This is not flagged.

## Timing
- Reset (async assert, any state):
  - pc = RESET_VEC, state = BOOT.
  - pc_valid = 0, misalign = 0, proto_err = 0, instret = 0, redirect_cnt = 0.
- First edge after deassertion enters FETCH. pc_valid is high in the 2nd cycle after release.
- Fetch handshake fires at the edge where pc_valid && pc_ready; state is EXEC the next cycle.
- Commit is sampled at the edge in EXEC. The new pc and pc_valid = 1 are visible the next cycle (commit-to-fetch latency 1).
- Minimum issue interval is 2 cycles per instruction with pc_ready tied high.
- Reset mid-EXEC discards the pending commit.
- misalign is registered: high exactly 1 cycle.

## Structure
- Shared package ysyx_23060187_pkg holds:
  - the br_op localparams (BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU).
  - the FSM state encoding (S_BOOT, S_FETCH, S_EXEC).
  - the default RESET_VEC.
- Sub-module ysyx_23060187_br_cmp: combinational, XLEN-parametrised. Inputs br_op, src1, src2; outputs taken and illegal.
- Everything else (FSM, next-PC mux, counters) lives in the top module.

## Test plan
- Reset release with pc_ready = 1:
  - pc = 0x8000_0000.
  - pc_valid low in cycle 1, high in cycle 2.
  - sequential commits give 0x8000_0004, then 0x8000_0008.
- Stall: pc_ready = 0 for 5 cycles → pc and pc_valid held. The state moves to EXEC only after ready rises.
- Branches at pc 0x8000_0010, imm = −16:
  - BLT, src1 = 0xFFFF_FFFF, src2 = 1 → 0x8000_0000.
  - BLTU with the same operands → 0x8000_0014.
  - redirect_cnt increments only on the BLT.
- JALR src1 = 0x8000_0101, imm = 2:
  - target 0x8000_0103 & ~1 = 0x8000_0102 → misalign pulse.
  - next pc = mtvec (0x8000_0200).
- Trap, then MRET (mepc = 0x8000_0040): pc goes to mtvec, then 0x8000_0040. is_trap with is_jal also high → mtvec wins.
- Errors and mid-operation reset:
  - commit_valid in FETCH → proto_err = 1, pc and instret unchanged.
  - br_op = 010 → not taken, proto_err set.
  - rst_n low in EXEC → all outputs return to reset values.
